// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with valid/ready handshake,
// a two-entry skid buffer (main + skid), synchronous flush and a
// saturating bubble counter. in_ready is decoded purely from state, so
// there is no combinational path from out_ready to in_ready.
module pipe_stage_skid #(
    parameter int               PC_W      = 8,
    parameter int               INSTR_W   = 20,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int               CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instr_out,
    input  logic               flush,
    output logic [1:0]         occupancy,
    input  logic               bub_clr,
    output logic [CNT_W-1:0]   bubble_cnt
);

    // Occupancy encoding doubles as the state encoding.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    main_pc_reg, main_pc_next;
    logic [INSTR_W-1:0] main_instr_reg, main_instr_next;
    logic [PC_W-1:0]    skid_pc_reg, skid_pc_next;
    logic [INSTR_W-1:0] skid_instr_reg, skid_instr_next;
    logic [CNT_W-1:0]   bubble_cnt_reg, bubble_cnt_next;

    logic accept;
    logic pop;

    // Handshake status decoded from the registered state only.
    always_comb begin
        in_ready  = (state_reg != FULL);
        out_valid = (state_reg != EMPTY);
        occupancy = state_reg;
        pc_out    = main_pc_reg;
        instr_out = main_instr_reg;
        bubble_cnt = bubble_cnt_reg;
        accept    = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Next-state and datapath selection; flush overrides everything.
    always_comb begin
        state_next      = state_reg;
        main_pc_next    = main_pc_reg;
        main_instr_next = main_instr_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;
        if (flush) begin
            // Any beat offered this cycle is dropped on purpose.
            state_next      = EMPTY;
            main_pc_next    = '0;
            main_instr_next = NOP_INSTR;
            skid_pc_next    = '0;
            skid_instr_next = '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next      = ONE;
                        main_pc_next    = pc_in;
                        main_instr_next = instr_in;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_pc_next    = pc_in;
                        main_instr_next = instr_in;
                    end else if (accept) begin
                        state_next      = FULL;
                        skid_pc_next    = pc_in;
                        skid_instr_next = instr_in;
                    end else if (pop) begin
                        // Outputs keep their last value; out_valid qualifies them.
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next      = ONE;
                        main_pc_next    = skid_pc_reg;
                        main_instr_next = skid_instr_reg;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Bubble counter: clear wins, otherwise saturating count of starved cycles.
    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        if (bub_clr) begin
            bubble_cnt_next = '0;
        end else if (out_ready && !out_valid && !flush && bubble_cnt_reg != CNT_MAX) begin
            bubble_cnt_next = bubble_cnt_reg + CNT_ONE;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Main and skid data registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_pc_reg    <= '0;
            main_instr_reg <= NOP_INSTR;
            skid_pc_reg    <= '0;
            skid_instr_reg <= '0;
        end else begin
            main_pc_reg    <= main_pc_next;
            main_instr_reg <= main_instr_next;
            skid_pc_reg    <= skid_pc_next;
            skid_instr_reg <= skid_instr_next;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubble_cnt_reg <= '0;
        end else begin
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid (CNT_W = 4, distinctive NOP_INSTR).
module tb_pipe_stage_skid;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 20;
    localparam int CNT_W   = 4;
    localparam logic [INSTR_W-1:0] NOP = 20'h5A5A5;

    logic               clk;
    logic               rstn;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] instr_out;
    logic               flush;
    logic [1:0]         occupancy;
    logic               bub_clr;
    logic [CNT_W-1:0]   bubble_cnt;

    int total;
    int bad;

    pipe_stage_skid #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instr_in(instr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instr_out(instr_out),
        .flush(flush), .occupancy(occupancy),
        .bub_clr(bub_clr), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] ins(input logic [PC_W-1:0] p);
        return {12'hC3A, p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PC_W-1:0] p, input logic r);
        in_valid  = v;
        pc_in     = p;
        instr_in  = ins(p);
        out_ready = r;
    endtask

    task automatic chk_state(input string name, input logic [1:0] occ,
                             input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] ins_e);
        total++;
        if (occupancy !== occ || out_valid !== (occ != 2'd0) || in_ready !== (occ != 2'd2)
            || pc_out !== p || instr_out !== ins_e) begin
            bad++;
            $display("FAIL %s: occ=%0d ov=%0b ir=%0b pc=%h ins=%h, required occ=%0d pc=%h ins=%h",
                     name, occupancy, out_valid, in_ready, pc_out, instr_out, occ, p, ins_e);
        end else begin
            $display("ok   %s: occ=%0d pc=%h ins=%h", name, occupancy, pc_out, instr_out);
        end
    endtask

    task automatic chk_bub(input string name, input logic [CNT_W-1:0] e);
        total++;
        if (bubble_cnt !== e) begin
            bad++;
            $display("FAIL %s: bubble_cnt=%0d required %0d", name, bubble_cnt, e);
        end else begin
            $display("ok   %s: bubble_cnt=%0d", name, bubble_cnt);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; bub_clr = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        #12;
        chk_state("reset_state", 2'd0, 8'h00, NOP);
        chk_bub("reset_bubble", 4'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_stream();
        // First edge sees out_ready with nothing valid: one bubble.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b1);
            step();
            chk_state($sformatf("stream_%0d", i), 2'd1, 8'(8'h10 + i), ins(8'(8'h10 + i)));
        end
        drive(1'b0, 8'h00, 1'b1);
        step();
        chk_state("stream_drain_hold", 2'd0, 8'h17, ins(8'h17));
        chk_bub("stream_one_bubble", 4'd1);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        drive(1'b1, 8'h20, 1'b0);
        step();
        chk_state("bp_main", 2'd1, 8'h20, ins(8'h20));
        drive(1'b1, 8'h21, 1'b0);
        step();
        chk_state("bp_full", 2'd2, 8'h20, ins(8'h20));
        drive(1'b1, 8'h22, 1'b0);
        step();
        chk_state("bp_hold", 2'd2, 8'h20, ins(8'h20));
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_comb_path: in_ready=%0b required 0", in_ready);
        end else begin
            $display("ok   bp_no_comb_path: in_ready=0");
        end
        step();
        chk_state("bp_pop_skid", 2'd1, 8'h21, ins(8'h21));
        step();
        chk_state("bp_pop_last", 2'd1, 8'h22, ins(8'h22));
        in_valid = 1'b0;
        step();
        chk_state("bp_empty", 2'd0, 8'h22, ins(8'h22));
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        drive(1'b1, 8'h28, 1'b0);
        step();
        drive(1'b1, 8'h29, 1'b0);
        step();
        chk_state("flush_prefill", 2'd2, 8'h28, ins(8'h28));
        drive(1'b1, 8'h30, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_state("flush_result", 2'd0, 8'h00, NOP);
        drive(1'b0, 8'h00, 1'b0);
        step();
        chk_state("flush_no_0x30", 2'd0, 8'h00, NOP);
    endtask

    task automatic test_accept_pop();
        drive(1'b1, 8'h40, 1'b0);
        step();
        chk_state("ap_main", 2'd1, 8'h40, ins(8'h40));
        drive(1'b1, 8'h41, 1'b1);
        step();
        chk_state("ap_swap", 2'd1, 8'h41, ins(8'h41));
        drive(1'b0, 8'h00, 1'b1);
        step();
        chk_state("ap_drain", 2'd0, 8'h41, ins(8'h41));
        out_ready = 1'b0;
    endtask

    task automatic test_bubble();
        chk_bub("bub_before_clr", 4'd1);
        bub_clr = 1'b1;
        step();
        bub_clr = 1'b0;
        chk_bub("bub_clr_idle", 4'd0);
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk_bub($sformatf("bub_cnt_%0d", i), (i + 1 > 15) ? 4'd15 : 4'(i + 1));
        end
        bub_clr = 1'b1;
        step();
        bub_clr = 1'b0;
        chk_bub("bub_clr_priority", 4'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_bub("bub_flush_no_inc", 4'd0);
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'h50, 1'b1);
        step();
        drive(1'b1, 8'h51, 1'b0);
        step();
        chk_state("ar_full", 2'd2, 8'h50, ins(8'h50));
        chk_bub("ar_bubble_pre", 4'd1);
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_state("ar_immediate", 2'd0, 8'h00, NOP);
        chk_bub("ar_bubble_clr", 4'd0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, 8'h60, 1'b0);
        step();
        chk_state("ar_first_accept", 2'd1, 8'h60, ins(8'h60));
        in_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_accept_pop();
        test_bubble();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
